wavefront_prune: RTL and testbench
==================================

WAVEFRONT_PRUNE -- requirements
Module: wavefront_prune

Interface
REQ-001 Parameter MAX_WAVEFRONT_LEN, default 32, number of diagonal lanes; SHALL be a power of two, at least 2.
REQ-002 Parameter LOG_MAX_TILE_SIZE, default 6, width of each offset entry.
REQ-003 Parameter DATA_WIDTH, default 8, width of numDiag and the K indices.
REQ-004 Parameter REF_LEN_WIDTH, default 8, width of threshold.
REQ-005 Parameter QUERY_LEN_WIDTH, default 8, width of queryLen.
REQ-006 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 start  input  1  request a prune pass; SHALL be sampled only in IDLE.
REQ-009 threshold  input  REF_LEN_WIDTH  keep threshold from the threshold calculator.
REQ-010 queryLen  input  QUERY_LEN_WIDTH  query length of the tile.
REQ-011 numDiag  input  DATA_WIDTH  lanes 0..numDiag+1 are candidates.
REQ-012 Kmin_in  input  DATA_WIDTH  diagonal index of lane 0.
REQ-013 OffsetReg  input  MAX_WAVEFRONT_LEN x LOG_MAX_TILE_SIZE  per-lane furthest-reaching offsets, unsigned.
REQ-014 valid_in  input  MAX_WAVEFRONT_LEN x 1  per-lane validity.
REQ-015 valid_out  output  MAX_WAVEFRONT_LEN x 1  pruned validity mask.
REQ-016 Kmin_out, Kmax_out  output  DATA_WIDTH each  diagonal indices of the first and last kept lanes.
REQ-017 numKept  output  $clog2(MAX_WAVEFRONT_LEN)+1  count of kept lanes.
REQ-018 allPruned  output  1  no lane was kept.
REQ-019 busy  output  1  high in LOAD, SCAN and DONE.
REQ-020 done  output  1  single-cycle completion pulse.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD, SCAN and DONE, with transitions IDLE->LOAD on start=1, LOAD->SCAN, SCAN->DONE after lane MAX_WAVEFRONT_LEN-1, and DONE->IDLE.
REQ-022 LOAD SHALL register all data inputs; inputs SHALL be don't-care after LOAD.
REQ-023 SCAN SHALL evaluate one lane per cycle, in ascending order from lane 0 to lane MAX_WAVEFRONT_LEN-1, using an index counter.
REQ-024 Lane j SHALL be kept iff j <= numDiag+1, valid_in[j]=1, and (offset + threshold) >= queryLen.
REQ-025 The j <= numDiag+1 compare SHALL use DATA_WIDTH+1 bits so that numDiag=all-ones does not wrap.
REQ-026 The keep-condition compare SHALL be unsigned, using max(REF_LEN_WIDTH, QUERY_LEN_WIDTH)+1 bits, with zero extension and no overflow.
REQ-027 Kmin_out SHALL equal Kmin_in plus the index of the first kept lane; Kmax_out SHALL equal Kmin_in plus the index of the last kept lane; both additions SHALL be modulo 2^DATA_WIDTH.
REQ-028 If no lane is kept: allPruned=1, numKept=0, Kmin_out=Kmax_out=Kmin_in, and valid_out all zero.
REQ-029 done SHALL pulse high for exactly one cycle, MAX_WAVEFRONT_LEN+2 rising edges after the edge that sampled start.
REQ-030 Outputs SHALL be stable when done=1 and SHALL hold until the next LOAD.
REQ-031 start SHALL be ignored while busy=1.
REQ-032 If start=1 in the DONE cycle, it SHALL be ignored; a new pass requires start in IDLE.
REQ-033 Back-to-back passes SHALL be possible, with start asserted on the cycle after done.

Reset
REQ-034 On rst=1, asynchronously: state=IDLE; valid_out=0; Kmin_out=0; Kmax_out=0; numKept=0; allPruned=0; busy=0; done=0.
REQ-035 A reset during LOAD, SCAN or DONE SHALL abort the pass with no done pulse.
REQ-036 After rst deasserts, the block SHALL accept start on the first following edge.

Verification
REQ-037 Basic prune: queryLen=50, threshold=20, numDiag=2, Kmin_in=5, valid_in all 1, offsets lane0..3 = 10,35,30,29 -> valid_out=0x00000006, Kmin_out=6, Kmax_out=7, numKept=2, allPruned=0, done 34 edges after start.
REQ-038 All pruned: same as REQ-037 but threshold=0 -> valid_out=0, numKept=0, allPruned=1, Kmin_out=Kmax_out=5.
REQ-039 Range limit: numDiag=29, all offsets 63, valid_in all 1, threshold=queryLen=8 -> valid_out=0x7FFFFFFF, numKept=31, Kmin_out=Kmin_in, Kmax_out=Kmin_in+30.
REQ-040 Wrap and validity: Kmin_in=250, numDiag=30, only valid_in[10]=1, keep condition true -> Kmin_out=Kmax_out=4, numKept=1.
REQ-041 Control: start pulsed again during SCAN -> no effect; rst asserted at the 5th SCAN cycle -> no done pulse and all outputs zero; a fresh start then completes normally.

Source files
------------

// File: rtl/wavefront_prune_if.sv
// Handshake and data bundle for wavefront_prune.
// The master side launches prune passes and the slave side returns the pruned lane mask.
interface wavefront_prune_if #(
  parameter int MAX_WAVEFRONT_LEN = 32,
  parameter int LOG_MAX_TILE_SIZE = 6,
  parameter int DATA_WIDTH        = 8,
  parameter int REF_LEN_WIDTH     = 8,
  parameter int QUERY_LEN_WIDTH   = 8
);
  logic                                                start;
  logic [REF_LEN_WIDTH-1:0]                            threshold;
  logic [QUERY_LEN_WIDTH-1:0]                          queryLen;
  logic [DATA_WIDTH-1:0]                               numDiag;
  logic [DATA_WIDTH-1:0]                               Kmin_in;
  logic [MAX_WAVEFRONT_LEN-1:0][LOG_MAX_TILE_SIZE-1:0] OffsetReg;
  logic [MAX_WAVEFRONT_LEN-1:0]                        valid_in;
  logic [MAX_WAVEFRONT_LEN-1:0]                        valid_out;
  logic [DATA_WIDTH-1:0]                               Kmin_out;
  logic [DATA_WIDTH-1:0]                               Kmax_out;
  logic [$clog2(MAX_WAVEFRONT_LEN):0]                  numKept;
  logic                                                allPruned;
  logic                                                busy;
  logic                                                done;

  modport master (
    output start, threshold, queryLen, numDiag, Kmin_in, OffsetReg, valid_in,
    input  valid_out, Kmin_out, Kmax_out, numKept, allPruned, busy, done
  );

  modport slave (
    input  start, threshold, queryLen, numDiag, Kmin_in, OffsetReg, valid_in,
    output valid_out, Kmin_out, Kmax_out, numKept, allPruned, busy, done
  );
endinterface

// File: rtl/wavefront_prune.sv
// Serial wavefront pruner: latches one wavefront, scans one lane per cycle and
// reports the kept-lane mask, the kept diagonal range and the kept count.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | capture all data inputs, clear result registers
// SCAN  | evaluate lane idx, lanes 0..MAX_WAVEFRONT_LEN-1 in order
// DONE  | results final, done pulse
module wavefront_prune #(
  parameter int MAX_WAVEFRONT_LEN = 32,
  parameter int LOG_MAX_TILE_SIZE = 6,
  parameter int DATA_WIDTH        = 8,
  parameter int REF_LEN_WIDTH     = 8,
  parameter int QUERY_LEN_WIDTH   = 8
) (
  input logic               clk,
  input logic               rst,
  wavefront_prune_if.slave  bus
);
  localparam int IW = $clog2(MAX_WAVEFRONT_LEN);
  localparam int LW = ((IW > DATA_WIDTH) ? IW : DATA_WIDTH) + 1;
  localparam int RQ = (REF_LEN_WIDTH > QUERY_LEN_WIDTH) ? REF_LEN_WIDTH : QUERY_LEN_WIDTH;
  localparam int CW = ((RQ > LOG_MAX_TILE_SIZE) ? RQ : LOG_MAX_TILE_SIZE) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;
  state_t state, state_nxt;

  logic [MAX_WAVEFRONT_LEN-1:0][LOG_MAX_TILE_SIZE-1:0] off_q;
  logic [MAX_WAVEFRONT_LEN-1:0] valid_q;
  logic [REF_LEN_WIDTH-1:0]     thr_q;
  logic [QUERY_LEN_WIDTH-1:0]   qlen_q;
  logic [DATA_WIDTH-1:0]        nd_q;
  logic [DATA_WIDTH-1:0]        kmin_q;
  logic [IW-1:0]                idx;

  logic          last_lane;
  logic [LW-1:0] lane_lim;
  logic          lane_ok;
  logic [CW-1:0] reach;
  logic          keep;

  assign last_lane = (idx == IW'(MAX_WAVEFRONT_LEN - 1));
  // Extra bit so numDiag = all-ones still admits every lane.
  assign lane_lim  = LW'(nd_q) + LW'(1);
  assign lane_ok   = (LW'(idx) <= lane_lim);
  assign reach     = CW'(off_q[idx]) + CW'(thr_q);
  assign keep      = lane_ok && valid_q[idx] && (reach >= CW'(qlen_q));

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    state_nxt = SCAN;
      SCAN:    if (last_lane) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q         <= '0;
      valid_q       <= '0;
      thr_q         <= '0;
      qlen_q        <= '0;
      nd_q          <= '0;
      kmin_q        <= '0;
      idx           <= '0;
      bus.valid_out <= '0;
      bus.Kmin_out  <= '0;
      bus.Kmax_out  <= '0;
      bus.numKept   <= '0;
      bus.allPruned <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          off_q         <= bus.OffsetReg;
          valid_q       <= bus.valid_in;
          thr_q         <= bus.threshold;
          qlen_q        <= bus.queryLen;
          nd_q          <= bus.numDiag;
          kmin_q        <= bus.Kmin_in;
          idx           <= '0;
          // Results default to the all-pruned answer until a lane is kept.
          bus.valid_out <= '0;
          bus.Kmin_out  <= bus.Kmin_in;
          bus.Kmax_out  <= bus.Kmin_in;
          bus.numKept   <= '0;
          bus.allPruned <= 1'b0;
        end
        SCAN: begin
          idx <= idx + IW'(1);
          if (keep) begin
            bus.valid_out[idx] <= 1'b1;
            bus.numKept        <= bus.numKept + 1'b1;
            bus.Kmax_out       <= kmin_q + DATA_WIDTH'(idx);
            if (bus.numKept == '0) bus.Kmin_out <= kmin_q + DATA_WIDTH'(idx);
          end
          if (last_lane) bus.allPruned <= (bus.numKept == '0) && !keep;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wavefront_prune.sv
// Directed bench for wavefront_prune: hand-computed prune results, done timing,
// start filtering, back-to-back passes and reset abort.
module tb_wavefront_prune;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  wavefront_prune_if bus ();
  wavefront_prune dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Drives one pass from a negedge; scrambles inputs once LOAD has passed.
  // edges = rising edges after the start edge up to the one that samples done=1.
  task automatic run_pass(input logic [7:0] thr, input logic [7:0] ql, input logic [7:0] nd,
                          input logic [7:0] kmin, input logic [31:0][5:0] offs,
                          input logic [31:0] vin, input int restart,
                          output int edges, output logic busy_mid);
    logic d;
    bus.threshold = thr; bus.queryLen = ql; bus.numDiag = nd;
    bus.Kmin_in = kmin; bus.OffsetReg = offs; bus.valid_in = vin;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    edges = 0; busy_mid = 1'b0; d = 1'b0;
    while (edges < 100) begin
      @(negedge clk);
      bus.start = (edges == restart);
      if (edges == 1) begin
        bus.threshold = 8'($urandom); bus.queryLen = 8'($urandom);
        bus.numDiag = 8'($urandom); bus.Kmin_in = 8'($urandom);
        bus.valid_in = $urandom;
        for (int i = 0; i < 32; i++) bus.OffsetReg[i] = 6'($urandom);
      end
      if (edges == 10) busy_mid = bus.busy;
      d = bus.done;
      @(posedge clk);
      edges++;
      if (d) break;
    end
    #1 bus.start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    checks++;
    if (bus.valid_out !== 32'h0 || bus.numKept !== 6'd0 || bus.allPruned !== 1'b0) begin
      errors++; $display("FAIL reset_result valid_out=%h numKept=%0d allPruned=%b expected 0 0 0",
                         bus.valid_out, bus.numKept, bus.allPruned);
    end
    checks++;
    if (bus.Kmin_out !== 8'd0 || bus.Kmax_out !== 8'd0) begin
      errors++; $display("FAIL reset_k Kmin=%0d Kmax=%0d expected 0 0", bus.Kmin_out, bus.Kmax_out);
    end
  endtask

  task automatic test_basic(input string name, input int restart);
    logic [31:0][5:0] o; int e; logic bm;
    o = '0; o[0] = 6'd10; o[1] = 6'd35; o[2] = 6'd30; o[3] = 6'd29;
    @(negedge clk);
    run_pass(8'd20, 8'd50, 8'd2, 8'd5, o, 32'hFFFF_FFFF, restart, e, bm);
    checks++;
    if (e !== 34) begin errors++; $display("FAIL %s done_edges got %0d expected 34", name, e); end
    checks++;
    if (bus.valid_out !== 32'h0000_0006) begin
      errors++; $display("FAIL %s valid_out got %h expected 00000006", name, bus.valid_out);
    end
    checks++;
    if (bus.Kmin_out !== 8'd6 || bus.Kmax_out !== 8'd7) begin
      errors++; $display("FAIL %s k_range got %0d..%0d expected 6..7", name, bus.Kmin_out, bus.Kmax_out);
    end
    checks++;
    if (bus.numKept !== 6'd2 || bus.allPruned !== 1'b0) begin
      errors++; $display("FAIL %s count got %0d/%b expected 2/0", name, bus.numKept, bus.allPruned);
    end
    checks++;
    if (bm !== 1'b1) begin errors++; $display("FAIL %s busy_mid got %b expected 1", name, bm); end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL %s done_width done=%b busy=%b expected 0 0", name, bus.done, bus.busy);
    end
  endtask

  task automatic test_all_pruned();
    logic [31:0][5:0] o; int e; logic bm;
    o = '0; o[0] = 6'd10; o[1] = 6'd35; o[2] = 6'd30; o[3] = 6'd29;
    @(negedge clk);
    run_pass(8'd0, 8'd50, 8'd2, 8'd5, o, 32'hFFFF_FFFF, -1, e, bm);
    checks++;
    if (e !== 34 || bus.valid_out !== 32'h0 || bus.numKept !== 6'd0 || bus.allPruned !== 1'b1) begin
      errors++; $display("FAIL all_pruned edges=%0d valid_out=%h numKept=%0d allPruned=%b expected 34 0 0 1",
                         e, bus.valid_out, bus.numKept, bus.allPruned);
    end
    checks++;
    if (bus.Kmin_out !== 8'd5 || bus.Kmax_out !== 8'd5) begin
      errors++; $display("FAIL all_pruned_k got %0d..%0d expected 5..5", bus.Kmin_out, bus.Kmax_out);
    end
  endtask

  task automatic test_range_limit();
    logic [31:0][5:0] o; int e; logic bm;
    o = {32{6'd63}};
    @(negedge clk);
    run_pass(8'd8, 8'd8, 8'd29, 8'd3, o, 32'hFFFF_FFFF, -1, e, bm);
    checks++;
    if (bus.valid_out !== 32'h7FFF_FFFF || bus.numKept !== 6'd31 || bus.allPruned !== 1'b0) begin
      errors++; $display("FAIL range_limit valid_out=%h numKept=%0d allPruned=%b expected 7fffffff 31 0",
                         bus.valid_out, bus.numKept, bus.allPruned);
    end
    checks++;
    if (bus.Kmin_out !== 8'd3 || bus.Kmax_out !== 8'd33) begin
      errors++; $display("FAIL range_limit_k got %0d..%0d expected 3..33", bus.Kmin_out, bus.Kmax_out);
    end
  endtask

  task automatic test_wrap();
    logic [31:0][5:0] o; int e; logic bm;
    o = '0;
    @(negedge clk);
    run_pass(8'd8, 8'd8, 8'd30, 8'd250, o, 32'h0000_0400, -1, e, bm);
    checks++;
    if (bus.valid_out !== 32'h0000_0400 || bus.numKept !== 6'd1) begin
      errors++; $display("FAIL wrap valid_out=%h numKept=%0d expected 00000400 1", bus.valid_out, bus.numKept);
    end
    checks++;
    if (bus.Kmin_out !== 8'd4 || bus.Kmax_out !== 8'd4) begin
      errors++; $display("FAIL wrap_k got %0d..%0d expected 4..4", bus.Kmin_out, bus.Kmax_out);
    end
  endtask

  // numDiag all-ones and a sum that overflows 8 bits: every lane kept.
  task automatic test_full_width();
    logic [31:0][5:0] o; int e; logic bm;
    o = {32{6'd5}};
    @(negedge clk);
    run_pass(8'd255, 8'd255, 8'd255, 8'h10, o, 32'hFFFF_FFFF, -1, e, bm);
    checks++;
    if (bus.valid_out !== 32'hFFFF_FFFF || bus.numKept !== 6'd32) begin
      errors++; $display("FAIL full_width valid_out=%h numKept=%0d expected ffffffff 32", bus.valid_out, bus.numKept);
    end
    checks++;
    if (bus.Kmin_out !== 8'h10 || bus.Kmax_out !== 8'h2F) begin
      errors++; $display("FAIL full_width_k got %h..%h expected 10..2f", bus.Kmin_out, bus.Kmax_out);
    end
  endtask

  task automatic test_start_in_done();
    logic [31:0][5:0] o; int e; logic bm;
    o = '0;
    @(negedge clk);
    run_pass(8'd8, 8'd8, 8'd30, 8'd0, o, 32'h0000_0001, 33, e, bm);
    checks++;
    if (e !== 34) begin errors++; $display("FAIL start_in_done edges got %0d expected 34", e); end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_in_done busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0][5:0] o; int e; logic bm;
    o = {32{6'd63}};
    run_pass(8'd0, 8'd63, 8'd0, 8'd100, o, 32'h0000_0002, -1, e, bm);
    checks++;
    if (e !== 34 || bus.valid_out !== 32'h0000_0002 || bus.numKept !== 6'd1 ||
        bus.Kmin_out !== 8'd101 || bus.Kmax_out !== 8'd101) begin
      errors++; $display("FAIL back_to_back edges=%0d valid_out=%h numKept=%0d k=%0d..%0d expected 34 00000002 1 101..101",
                         e, bus.valid_out, bus.numKept, bus.Kmin_out, bus.Kmax_out);
    end
  endtask

  task automatic test_abort();
    logic [31:0][5:0] o; logic saw_done;
    o = '0; o[0] = 6'd10; o[1] = 6'd35; o[2] = 6'd30; o[3] = 6'd29;
    @(negedge clk);
    bus.threshold = 8'd20; bus.queryLen = 8'd50; bus.numDiag = 8'd2;
    bus.Kmin_in = 8'd5; bus.OffsetReg = o; bus.valid_in = 32'hFFFF_FFFF;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.valid_out !== 32'h0 || bus.numKept !== 6'd0 || bus.Kmin_out !== 8'd0 ||
        bus.Kmax_out !== 8'd0 || bus.allPruned !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort_clear valid_out=%h numKept=%0d k=%0d..%0d allPruned=%b busy=%b expected all 0",
                         bus.valid_out, bus.numKept, bus.Kmin_out, bus.Kmax_out, bus.allPruned, bus.busy);
    end
    saw_done = 1'b0;
    repeat (3) begin @(negedge clk); saw_done |= bus.done; end
    rst = 1'b0;
    repeat (40) begin @(negedge clk); saw_done |= bus.done; end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done saw done=%b expected 0", saw_done); end
  endtask

  initial begin
    bus.start = 1'b0; bus.threshold = '0; bus.queryLen = '0; bus.numDiag = '0;
    bus.Kmin_in = '0; bus.OffsetReg = '0; bus.valid_in = '0;
    #23;
    test_reset();
    rst = 1'b0;
    test_basic("basic", -1);
    test_all_pruned();
    test_range_limit();
    test_wrap();
    test_full_width();
    test_basic("restart_in_scan", 10);
    test_start_in_done();
    test_back_to_back();
    test_abort();
    test_basic("after_abort", -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
